apb_ram: RTL and testbench

//  APB-style slave fronting a small word-addressed 32-bit RAM. It decodes psel/pen/wr_en transfers and writes or

---
 rtl/apb_ram_pkg.sv | 17 +
 rtl/apb_ram_mem.sv | 44 ++++
 rtl/apb_ram.sv | 120 ++++++++++++
 tb/tb_apb_ram.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_ram_pkg.sv
// Shared types and default sizes for the APB scratch RAM.
// Optional build macro: APB_RAM_WAIT_STATE_EN (used by apb_ram.sv).
package apb_ram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;

  // WAIT is only reachable when the wait-state build option is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_ram_mem.sv
// DEPTH x DATA_W word store with single write port, combinational read
// and a synchronous clear of every word on rst.
module apb_ram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next-state of every word: only the addressed word takes the write data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (addr == AW'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  // Word storage; reset clears the whole array so cleared memory reads as zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // The top registers this value into prdata, so the read path stays a single
  // register stage from address to output.
  assign rdata = mem_q[addr];

endmodule

// File: rtl/apb_ram.sv
// APB-style slave in front of a small word-addressed RAM.
// Build option: define APB_RAM_WAIT_STATE_EN to insert a WAIT state between
// SETUP and ACCESS (op commits entering WAIT, pready one cycle later).
module apb_ram
  import apb_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              wr_en,
  input  logic              psel,
  input  logic              pen,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pselverr
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  apb_state_t        state_q, state_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pselverr_q, pselverr_d;
  logic              err_q, err_d;

  logic              commit;
  logic              addr_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign addr_err = ({1'b0, paddr} >= DEPTH_W);

  apb_ram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (paddr[MEM_AW-1:0]),
    .wdata (pwdata),
    .rdata (mem_rdata)
  );

  // Next-state logic; commit marks the one edge on which the op is performed.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel) state_d = SETUP;
      end
      SETUP: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (pen) begin
          commit = 1'b1;
`ifdef APB_RAM_WAIT_STATE_EN
          state_d = WAIT;
`else
          state_d = ACCESS;
`endif
        end
      end
      WAIT: begin
`ifdef APB_RAM_WAIT_STATE_EN
        // Op is already committed here; dropping psel/pen only suppresses pready.
        state_d = (psel && pen) ? ACCESS : IDLE;
`else
        state_d = IDLE;
`endif
      end
      ACCESS: begin
        state_d = (psel && !pen) ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: write enable, read capture and the registered response flags.
  always_comb begin
    mem_we   = commit && wr_en && !addr_err;
    err_d    = commit ? addr_err : err_q;
    prdata_d = prdata_q;
    if (commit && !wr_en) begin
      prdata_d = addr_err ? '0 : mem_rdata;
    end
    pready_d   = (state_d == ACCESS);
    pselverr_d = (state_d == ACCESS) && err_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pselverr_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pselverr_q <= pselverr_d;
      err_q      <= err_d;
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pselverr = pselverr_q;

endmodule

// File: tb/tb_apb_ram.sv
// Self-checking bench for apb_ram: directed vector table, hand-written
// abort/reset sequences and a randomized run against a word-array model.
module tb_apb_ram;

  localparam int DEPTH = 64;
`ifdef APB_RAM_WAIT_STATE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  paddr = '0;
  logic        wr_en = 1'b0;
  logic        psel = 1'b0;
  logic        pen = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pselverr;

  apb_ram dut (
    .clk      (clk),
    .rst      (rst),
    .paddr    (paddr),
    .wr_en    (wr_en),
    .psel     (psel),
    .pen      (pen),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pselverr (pselverr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain word array plus the last value prdata should hold.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_prdata;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          keep;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_prdata = '0;
  endtask

  task automatic model_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] exp_rd, output logic exp_err);
    exp_err = (int'(a) >= DEPTH);
    if (wr) begin
      if (!exp_err) model_mem[a[5:0]] = d;
      exp_rd = model_prdata;
    end else begin
      exp_rd = exp_err ? 32'h0 : model_mem[a[5:0]];
    end
    model_prdata = exp_rd;
  endtask

  // One transfer starting from IDLE or ACCESS; keep=1 leaves psel high for a
  // back-to-back follow-up, otherwise the bus returns to idle.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit keep,
                      output logic [31:0] rd, output logic err);
    int k;
    bit seen;
    psel = 1'b1; pen = 1'b0; wr_en = wr; paddr = a; pwdata = d;
    step();
    check("ready_in_setup", pready, 1'b0);
    pen = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < LAT + 3) begin
      step();
      k++;
      if (pready) seen = 1'b1;
    end
    check("latency", seen ? k : 99, LAT);
    rd = prdata;
    err = pselverr;
    if (!keep) begin
      // Garbage on the bus during ACCESS must not start another op.
      psel = 1'b0; pen = 1'b0; wr_en = 1'b1; paddr = 8'h00; pwdata = 32'hFFFF_FFFF;
      step();
      check("ready_drop", pready, 1'b0);
      check("err_drop", pselverr, 1'b0);
    end
  endtask

  task automatic xfer_model(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit keep,
                            input string tag);
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    model_op(wr, a, d, exp_rd, exp_err);
    xfer(wr, a, d, keep, rd, err);
    check({tag, "_prdata"}, rd, exp_rd);
    check({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_rd;
    logic        exp_err;

    vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 8'h50, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[3]  = '{1'b0, 8'h50, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[4]  = '{1'b1, 8'h01, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 8'h01, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0};
    vecs[6]  = '{1'b1, 8'h3F, 32'hCAFEF00D, 1'b0, 32'hA5A5A5A5, 1'b0};
    vecs[7]  = '{1'b0, 8'h3F, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b1, 8'h40, 32'h11111111, 1'b0, 32'hCAFEF00D, 1'b1};
    vecs[9]  = '{1'b0, 8'h40, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 32'h0,        1'b0, 32'h0,        1'b1};

    // Reset held for two cycles.
    rst = 1'b1;
    step();
    step();
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", pready, 1'b0);
    check("rst_pselverr", pselverr, 1'b0);
    rst = 1'b0;
    model_reset();
    xfer_model(1'b0, 8'h05, 32'h0, 1'b0, "rst_read05");

    // Directed vector table.
    foreach (vecs[i]) begin
      model_op(vecs[i].wr, vecs[i].addr, vecs[i].data, exp_rd, exp_err);
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].keep, rd, err);
      $display("vec %0d wr=%0b addr=%h data=%h -> prdata=%h err=%0b", i, vecs[i].wr,
               vecs[i].addr, vecs[i].data, rd, err);
      check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

    // Aborted transfer: SETUP without pen, then psel drops.
    psel = 1'b1; pen = 1'b0; wr_en = 1'b1; paddr = 8'h10; pwdata = 32'h0BAD_0BAD;
    step();
    step();
    check("abort_setup_ready", pready, 1'b0);
    psel = 1'b0;
    step();
    check("abort_idle_ready", pready, 1'b0);
    step();
    check("abort_idle_ready2", pready, 1'b0);
    xfer_model(1'b0, 8'h10, 32'h0, 1'b0, "abort_readback");

    // Reset arriving in SETUP while pen rises: write must be lost, memory cleared.
    psel = 1'b1; pen = 1'b0; wr_en = 1'b1; paddr = 8'h3F; pwdata = 32'h7777_7777;
    step();
    pen = 1'b1;
    rst = 1'b1;
    step();
    check("midrst_ready", pready, 1'b0);
    check("midrst_prdata", prdata, 32'h0);
    rst = 1'b0; psel = 1'b0; pen = 1'b0;
    step();
    check("midrst_idle_ready", pready, 1'b0);
    model_reset();
    xfer_model(1'b0, 8'h3F, 32'h0, 1'b0, "midrst_read3f");
    xfer_model(1'b0, 8'h10, 32'h0, 1'b0, "midrst_read10");

    // Randomized transfers, mixed back-to-back and idle gaps.
    for (int i = 0; i < 150; i++) begin
      bit          wr;
      logic [7:0]  a;
      logic [31:0] d;
      bit          keep;
      wr = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
      d = $urandom;
      keep = (i < 149) && ($urandom_range(0, 1) == 1);
      xfer_model(wr, a, d, keep, $sformatf("rnd%0d", i));
      $display("rnd %0d wr=%0b addr=%h data=%h keep=%0b prdata=%h", i, wr, a, d, keep, prdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
